// File: rtl/pulse_meas_pkg.sv
// Shared types and constants for the pulse_meas block: FSM state encoding and
// the default count width.
package pulse_meas_pkg;

  localparam int CNT_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

endpackage : pulse_meas_pkg

// File: rtl/pulse_meas_sat_cnt.sv
// Saturating up-counter with clear and load-one; sat flags the all-ones value.
// Priority: reset/clr > ld1 > inc.
module sat_cnt
  import pulse_meas_pkg::*;
#(
  parameter int W = CNT_W_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         ld1,
  input  logic         inc,
  output logic [W-1:0] q,
  output logic         sat
);

  localparam logic [W-1:0] MAX_VAL = '1;

  assign sat = (q == MAX_VAL);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values, independent of block ordering.
  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      q <= '0;
    end else if (ld1) begin
      q <= W'(1);
    end else if (inc && !sat) begin
      q <= q + W'(1);
    end
  end

endmodule : sat_cnt

// File: rtl/pulse_meas.sv
// Measures high time and rising-to-rising period from sync_edge pulses and
// hands results out through a valid/ready register with loss reporting.
module pulse_meas
  import pulse_meas_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             edge_pos,
  input  logic             edge_neg,
  output logic             meas_valid,
  input  logic             meas_ready,
  output logic [CNT_W-1:0] high_cnt,
  output logic [CNT_W-1:0] period_cnt,
  output logic             meas_ovf,
  output logic             meas_lost
);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] high_q;
  logic             ovf_run;
  logic             cnt_sat;

  logic ep;
  logic en;
  logic complete;
  logic xfer;
  logic load;
  logic cnt_clr;
  logic cnt_ld1;
  logic cnt_inc;

  // Coincident edges cancel out: the pulse was too short to resolve.
  assign ep = edge_pos & ~edge_neg;
  assign en = edge_neg & ~edge_pos;

  assign complete = enable && (state == LOW) && ep;
  assign xfer     = meas_valid && meas_ready;
  assign load     = complete && (!meas_valid || meas_ready);

  // A rise in any active state starts a fresh count, giving gapless periods.
  assign cnt_clr = !enable || ((state == IDLE) && !ep);
  assign cnt_ld1 = enable && ep;
  assign cnt_inc = enable && (state != IDLE);

  sat_cnt #(.W(CNT_W)) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .ld1   (cnt_ld1),
    .inc   (cnt_inc),
    .q     (cnt),
    .sat   (cnt_sat)
  );

  always_ff @(posedge clk) begin
    if (!rst_n || !enable) begin
      state   <= IDLE;
      high_q  <= '0;
      ovf_run <= 1'b0;
    end else begin
      if (ep) begin
        ovf_run <= 1'b0;
      end else if ((state != IDLE) && cnt_sat) begin
        ovf_run <= 1'b1;
      end
      unique case (state)
        IDLE: if (ep) state <= HIGH;
        // A rise here means the fall was missed: the count restarts, stay HIGH.
        HIGH: if (en) begin
          high_q <= cnt;
          state  <= LOW;
        end
        LOW:  if (ep) state <= HIGH;
        default: state <= IDLE;
      endcase
    end
  end

  // Output register: a held result is never overwritten until transferred.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meas_valid <= 1'b0;
      high_cnt   <= '0;
      period_cnt <= '0;
      meas_ovf   <= 1'b0;
      meas_lost  <= 1'b0;
    end else begin
      meas_lost <= complete && meas_valid && !meas_ready;
      if (load) begin
        meas_valid <= 1'b1;
        high_cnt   <= high_q;
        period_cnt <= cnt;
        meas_ovf   <= ovf_run | cnt_sat;
      end else if (xfer) begin
        meas_valid <= 1'b0;
      end
    end
  end

endmodule : pulse_meas

// File: tb/tb_pulse_meas.sv
// Self-checking bench for pulse_meas (CNT_W=8): timestamp-based reference model
// compared every cycle, plus directed literal checks.
module tb_pulse_meas;
  import pulse_meas_pkg::*;

  localparam int W    = 8;
  localparam int MAXV = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         enable;
  logic         edge_pos;
  logic         edge_neg;
  logic         meas_valid;
  logic         meas_ready;
  logic [W-1:0] high_cnt;
  logic [W-1:0] period_cnt;
  logic         meas_ovf;
  logic         meas_lost;

  int n_cmp = 0;
  int n_bad = 0;

  pulse_meas #(.CNT_W(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .edge_pos   (edge_pos),
    .edge_neg   (edge_neg),
    .meas_valid (meas_valid),
    .meas_ready (meas_ready),
    .high_cnt   (high_cnt),
    .period_cnt (period_cnt),
    .meas_ovf   (meas_ovf),
    .meas_lost  (meas_lost)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int clip(input int v);
    return (v > MAXV) ? MAXV : v;
  endfunction

  // Reference model: remembers when the current period rose and fell, and
  // derives results from timestamp differences.
  int t = 0;
  bit have_rise = 0, have_fall = 0;
  int t_rise = 0, t_fall = 0;
  bit m_valid = 0, m_ovf = 0, m_lost = 0;
  int m_high = 0, m_period = 0;

  initial forever begin
    bit got;
    int r_h, r_p;
    bit r_o;
    @(negedge clk);
    check("valid",  32'(meas_valid), 32'(m_valid));
    check("lost",   32'(meas_lost),  32'(m_lost));
    check("high",   32'(high_cnt),   32'(m_high));
    check("period", 32'(period_cnt), 32'(m_period));
    check("ovf",    32'(meas_ovf),   32'(m_ovf));
    // Advance the model with the inputs the coming rising edge will sample.
    got = 0; r_h = 0; r_p = 0; r_o = 0;
    if (!rst_n) begin
      have_rise = 0; have_fall = 0;
      m_valid = 0; m_lost = 0; m_high = 0; m_period = 0; m_ovf = 0;
    end else begin
      m_lost = 0;
      if (!enable) begin
        have_rise = 0; have_fall = 0;
      end else if (edge_pos && !edge_neg) begin
        if (have_rise && have_fall) begin
          got = 1;
          r_p = clip(t - t_rise);
          r_h = clip(t_fall - t_rise);
          r_o = (t - t_rise) >= MAXV;
        end
        have_rise = 1; have_fall = 0; t_rise = t;
      end else if (edge_neg && !edge_pos && have_rise && !have_fall) begin
        have_fall = 1; t_fall = t;
      end
      if (got && (!m_valid || meas_ready)) begin
        m_valid = 1; m_high = r_h; m_period = r_p; m_ovf = r_o;
      end else if (got) begin
        m_lost = 1;
      end else if (m_valid && meas_ready) begin
        m_valid = 0;
      end
    end
    t++;
  end

  task automatic cyc(input logic ep, input logic en);
    edge_pos = ep;
    edge_neg = en;
    @(posedge clk);
    #1;
    edge_pos = 1'b0;
    edge_neg = 1'b0;
  endtask

  // Remainder of a waveform whose rise was just driven: fall after h, rise due after h+l.
  task automatic rest(input int h, input int l);
    repeat (h - 1) cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b1);
    repeat (l - 1) cyc(1'b0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; edge_pos = 1'b0; edge_neg = 1'b0; meas_ready = 1'b1;
    repeat (2) cyc(1'b0, 1'b0);
    check("rst_valid", 32'(meas_valid), 32'd0);
    check("rst_period", 32'(period_cnt), 32'd0);
    rst_n = 1'b1; enable = 1'b1;
    cyc(1'b0, 1'b0);

    // Repeated 5 high / 7 low, consumer always ready.
    cyc(1'b1, 1'b0);
    check("s1_first_noresult", 32'(meas_valid), 32'd0);
    for (int i = 0; i < 3; i++) begin
      rest(5, 7);
      cyc(1'b1, 1'b0);
      check("s1_valid", 32'(meas_valid), 32'd1);
      check("s1_high", 32'(high_cnt), 32'd5);
      check("s1_period", 32'(period_cnt), 32'd12);
      check("s1_ovf", 32'(meas_ovf), 32'd0);
    end

    // Long low saturates the period, next one is clean.
    rest(3, 300);
    cyc(1'b1, 1'b0);
    check("s2_period_sat", 32'(period_cnt), 32'd255);
    check("s2_high", 32'(high_cnt), 32'd3);
    check("s2_ovf", 32'(meas_ovf), 32'd1);
    rest(4, 6);
    cyc(1'b1, 1'b0);
    check("s2_period", 32'(period_cnt), 32'd10);
    check("s2_ovf_clear", 32'(meas_ovf), 32'd0);

    // Back-pressure: second completion is lost, first stays put.
    rest(5, 7);
    meas_ready = 1'b0;
    cyc(1'b1, 1'b0);
    check("s3_first_high", 32'(high_cnt), 32'd5);
    rest(2, 4);
    cyc(1'b1, 1'b0);
    check("s3_lost", 32'(meas_lost), 32'd1);
    check("s3_hold_period", 32'(period_cnt), 32'd12);
    cyc(1'b0, 1'b0);
    check("s3_lost_once", 32'(meas_lost), 32'd0);
    meas_ready = 1'b1;
    cyc(1'b0, 1'b0);
    check("s3_transferred", 32'(meas_valid), 32'd0);

    // Coincident edges mid-HIGH are ignored and still counted as high time.
    cyc(1'b1, 1'b1);
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b1);
    repeat (2) cyc(1'b0, 1'b0);
    cyc(1'b1, 1'b0);
    check("s4_high", 32'(high_cnt), 32'd5);
    check("s4_period", 32'(period_cnt), 32'd8);

    // Disable mid-LOW with a pending result.
    meas_ready = 1'b0;
    rest(3, 3);
    enable = 1'b0;
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);
    check("s5_idle", 32'(dut.state), 32'(IDLE));
    enable = 1'b1;
    check("s5_pending", 32'(meas_valid), 32'd1);
    check("s5_pending_high", 32'(high_cnt), 32'd5);
    meas_ready = 1'b1;
    cyc(1'b0, 1'b0);
    check("s5_delivered", 32'(meas_valid), 32'd0);
    cyc(1'b0, 1'b1);
    cyc(1'b1, 1'b0);
    check("s5_fresh_noresult", 32'(meas_valid), 32'd0);
    rest(2, 3);
    cyc(1'b1, 1'b0);
    check("s5_high", 32'(high_cnt), 32'd2);
    check("s5_period", 32'(period_cnt), 32'd5);

    // Reset during HIGH with a held result.
    meas_ready = 1'b0;
    cyc(1'b0, 1'b0);
    rst_n = 1'b0;
    cyc(1'b0, 1'b0);
    check("s6_valid", 32'(meas_valid), 32'd0);
    check("s6_high", 32'(high_cnt), 32'd0);
    check("s6_period", 32'(period_cnt), 32'd0);
    check("s6_state", 32'(dut.state), 32'(IDLE));
    rst_n = 1'b1; meas_ready = 1'b1;
    cyc(1'b0, 1'b1);
    cyc(1'b1, 1'b0);
    check("s6_fresh_noresult", 32'(meas_valid), 32'd0);
    rest(3, 4);
    cyc(1'b1, 1'b0);
    check("s6_high_after", 32'(high_cnt), 32'd3);
    check("s6_period_after", 32'(period_cnt), 32'd7);
    repeat (3) cyc(1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_pulse_meas

// File: doc/pulse_meas.md
PULSE_MEAS -- requirements
Module: pulse_meas

Interface
REQ-001 The block SHALL have one parameter: CNT_W, default 16, width of all count fields (legal range 4..32).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all logic on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1: reset is synchronous and active-low.
REQ-004 The block SHALL have port enable, input, 1: measurement enable; low forces IDLE.
REQ-005 The block SHALL have port edge_pos, input, 1: single-cycle rising-edge pulse from the upstream sync_edge stage.
REQ-006 The block SHALL have port edge_neg, input, 1: single-cycle falling-edge pulse from the upstream sync_edge stage.
REQ-007 The block SHALL have port meas_valid, output, 1: a result is held on the output fields.
REQ-008 The block SHALL have port meas_ready, input, 1: consumer accepts the result.
REQ-009 The block SHALL have port high_cnt, output, CNT_W: high time in clk cycles.
REQ-010 The block SHALL have port period_cnt, output, CNT_W: rising-to-rising period in clk cycles.
REQ-011 The block SHALL have port meas_ovf, output, 1: the counter saturated during this result.
REQ-012 The block SHALL have port meas_lost, output, 1: one-cycle pulse when a completed result is discarded.

Function
REQ-013 The FSM SHALL have states IDLE, HIGH and LOW.
REQ-014 IDLE: the counter SHALL be held at 0; edge_neg is ignored; edge_pos -> HIGH, with cnt<=1 and ovf_run<=0.
REQ-015 HIGH: each cycle, cnt SHALL increment; edge_neg -> LOW, with high_q<=cnt.
REQ-016 LOW: each cycle, cnt SHALL increment; edge_pos SHALL complete a measurement (period=cnt, high=high_q, ovf=ovf_run), then -> HIGH with cnt<=1 and ovf_run<=0 in the same cycle, so that back-to-back periods are measured gaplessly.
REQ-017 Timing: for an input high for H cycles and low for L cycles, the reported values SHALL be high_cnt=H and period_cnt=H+L.
REQ-018 The counter SHALL saturate at 2^CNT_W-1 and never wrap; reaching the saturation value SHALL set ovf_run, which remains set until the next measurement start.
REQ-019 edge_pos and edge_neg asserted in the same cycle SHALL be treated as neither edge; counting continues.
REQ-020 edge_pos while in HIGH (missed fall) SHALL restart the measurement (cnt<=1, stay HIGH) and SHALL produce no result.
REQ-021 edge_neg while in LOW SHALL be ignored.
REQ-022 Output handshake: on completion with meas_valid=0, or with meas_valid=1 and meas_ready=1, the result SHALL be loaded into the output registers and meas_valid<=1, visible one cycle after the completing edge_pos.
REQ-023 A transfer SHALL occur when meas_valid and meas_ready are both high; meas_valid then clears unless a new result loads in the same cycle.
REQ-024 Completion while meas_valid=1 and meas_ready=0 SHALL discard the new result, leave the output fields stable, and assert meas_lost for exactly one cycle.
REQ-025 Output fields SHALL remain constant while meas_valid=1 and no transfer has occurred.
REQ-026 enable=0 SHALL force IDLE and clear cnt, high_q and ovf_run on the next clock; a pending output result SHALL remain valid until consumed.
REQ-027 While enable=0, edges SHALL be ignored.

Reset
REQ-028 When rst_n=0 at a clk edge, the state SHALL become IDLE, and cnt, high_q and ovf_run SHALL become 0.
REQ-029 When rst_n=0 at a clk edge, the outputs SHALL become meas_valid=0, high_cnt=0, period_cnt=0, meas_ovf=0 and meas_lost=0.
REQ-030 Reset asserted mid-measurement or with a pending result SHALL abandon both with no output activity.

Structure
REQ-031 The state enumeration and the default CNT_W constant SHALL reside in the shared package pulse_meas_pkg.
REQ-032 The saturating counter SHALL be a sub-module named sat_cnt (ports: clk, rst_n, clr, ld1, inc, q, sat).
REQ-033 The block SHALL not contain edge detection; it consumes sync_edge outputs only.

Verification (CNT_W=8)
REQ-034 The bench SHALL cover: input high 5 and low 7, repeated, meas_ready=1 -> each completion yields high_cnt=5 and period_cnt=12, meas_ovf=0, with meas_valid one cycle after each edge_pos.
REQ-035 The bench SHALL cover: input high 3, then low 300 -> period_cnt=255, high_cnt=3, meas_ovf=1; the next period of 10 is reported with meas_ovf=0.
REQ-036 The bench SHALL cover: meas_ready=0 across two completions -> the first result stays stable, meas_lost pulses one cycle at the second completion, and the first result transfers when meas_ready=1.
REQ-037 The bench SHALL cover: edge_pos and edge_neg in the same cycle during HIGH -> no state change, and high_cnt includes that cycle.
REQ-038 The bench SHALL cover: enable=0 for 2 cycles mid-LOW with a pending result -> IDLE, the pending result is still delivered, and the first edge_pos afterwards starts a fresh measurement with no result.
REQ-039 The bench SHALL cover: rst_n=0 for 1 cycle during HIGH with meas_valid=1 -> all outputs are 0 on the next cycle and the FSM is in IDLE.
